// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B4 classic arbiter that shares one RAM slave port among NUM_MASTERS requesters.
// Optional stalled-slave timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_ram_arbiter #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [32*NUM_MASTERS-1:0]   i_m_adr,
    input  logic [32*NUM_MASTERS-1:0]   i_m_dat,
    input  logic [4*NUM_MASTERS-1:0]    i_m_sel,
    input  logic [NUM_MASTERS-1:0]      i_m_we,
    input  logic [NUM_MASTERS-1:0]      i_m_cyc,
    input  logic [NUM_MASTERS-1:0]      i_m_stb,
    output logic [32*NUM_MASTERS-1:0]   o_m_dat,
    output logic [NUM_MASTERS-1:0]      o_m_ack,
    output logic [NUM_MASTERS-1:0]      o_m_err,
    output logic [31:0]                 o_s_adr,
    output logic [31:0]                 o_s_dat,
    output logic [3:0]                  o_s_sel,
    output logic                        o_s_we,
    output logic                        o_s_cyc,
    output logic                        o_s_stb,
    input  logic [31:0]                 i_s_dat,
    input  logic                        i_s_ack
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT == 0) begin : g_param_check
        $error("wb_ram_arbiter: NUM_MASTERS must be 2..4 and TIMEOUT nonzero");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] rr_next;
    logic             owner_cyc;
    logic             owner_stb;
    logic             to_hit;

    // First requester found searching upward cyclically from the rr pointer.
    always_comb begin
        pick = rr_ptr;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            int unsigned cand;
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (i_m_cyc[IDX_W'(cand)]) begin
                pick = IDX_W'(cand);
                break;
            end
        end
    end

    assign rr_next   = ((32'(owner) + 32'd1) >= NUM_MASTERS) ? '0 : IDX_W'(32'(owner) + 32'd1);
    assign owner_cyc = (state == OWNED) && i_m_cyc[owner];
    assign owner_stb = owner_cyc && i_m_stb[owner];

    // Grant is held for the owner's whole CYC; release always passes through one IDLE cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_m_cyc) begin
                        owner <= pick;
                        state <= OWNED;
                    end
                end
                OWNED: begin
                    if (!i_m_cyc[owner]) begin
                        rr_ptr <= rr_next;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt;

    assign to_hit = (state == OWNED) && (to_cnt == CNT_W'(TIMEOUT));

    // Counts stalled strobe cycles of the current owner; restarts after each error pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            to_cnt <= '0;
        end else if (!owner_cyc || i_s_ack || to_hit) begin
            to_cnt <= '0;
        end else if (owner_stb) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Owner's request is muxed straight onto the slave port; non-owners see zeros.
    always_comb begin
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        o_m_dat = '0;
        o_m_ack = '0;
        o_m_err = '0;
        if (state == OWNED) begin
            o_s_adr = i_m_adr[owner*32 +: 32];
            o_s_dat = i_m_dat[owner*32 +: 32];
            o_s_sel = i_m_sel[owner*4 +: 4];
            o_s_we  = i_m_we[owner];
            o_s_cyc = owner_cyc && !to_hit;
            o_s_stb = owner_stb && !to_hit;
            o_m_dat[owner*32 +: 32] = i_s_dat;
            o_m_ack[owner]          = i_s_ack && owner_cyc && !to_hit;
            o_m_err[owner]          = to_hit;
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed self-checking bench for wb_ram_arbiter: single transfer, round-robin, lock, reset, timeout.
module tb_wb_ram_arbiter;

    localparam int unsigned N = 3;

    logic            clk = 1'b0;
    logic            i_reset;
    logic [32*N-1:0] m_adr;
    logic [32*N-1:0] m_dat;
    logic [4*N-1:0]  m_sel;
    logic [N-1:0]    m_we;
    logic [N-1:0]    m_cyc;
    logic [N-1:0]    m_stb;
    logic [32*N-1:0] o_m_dat;
    logic [N-1:0]    o_m_ack;
    logic [N-1:0]    o_m_err;
    logic [31:0]     o_s_adr;
    logic [31:0]     o_s_dat;
    logic [3:0]      o_s_sel;
    logic            o_s_we;
    logic            o_s_cyc;
    logic            o_s_stb;
    logic [31:0]     s_dat;
    logic            s_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter #(
        .NUM_MASTERS(N),
        .TIMEOUT    (8)
    ) dut (
        .i_clk  (clk),
        .i_reset(i_reset),
        .i_m_adr(m_adr),
        .i_m_dat(m_dat),
        .i_m_sel(m_sel),
        .i_m_we (m_we),
        .i_m_cyc(m_cyc),
        .i_m_stb(m_stb),
        .o_m_dat(o_m_dat),
        .o_m_ack(o_m_ack),
        .o_m_err(o_m_err),
        .o_s_adr(o_s_adr),
        .o_s_dat(o_s_dat),
        .o_s_sel(o_s_sel),
        .o_s_we (o_s_we),
        .o_s_cyc(o_s_cyc),
        .o_s_stb(o_s_stb),
        .i_s_dat(s_dat),
        .i_s_ack(s_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        m_cyc[k]          = cyc;
        m_stb[k]          = stb;
        m_we[k]           = we;
        m_adr[32*k +: 32] = adr;
        m_dat[32*k +: 32] = dat;
        m_sel[4*k +: 4]   = sel;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        s_dat = '0;
        s_ack = 1'b0;
        next_cycle();
        next_cycle();
        i_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int       order[$];
        int       ack_cyc[$];
        int       exp_order[6];
        logic [2:0] drop;
        int       cyc_cnt;
        int       err_cnt;

        // Reset state
        do_reset();
        settle();
        check("rst_s_ctrl", {o_s_cyc, o_s_stb, o_s_we}, 3'b000);
        check("rst_m_ack",  o_m_ack, 3'b000);
        check("rst_m_err",  o_m_err, 3'b000);

        // Single master write from m1
        drive(1, 1'b1, 1'b1, 1'b1, 32'h3000_1004, 32'hDEAD_BEEF, 4'hF);
        settle();
        check("t1_idle_stb", o_s_stb, 1'b0);
        next_cycle(); settle();
        check("t1_stb",    o_s_stb, 1'b1);
        check("t1_adr",    o_s_adr, 32'h3000_1004);
        check("t1_dat",    o_s_dat, 32'hDEAD_BEEF);
        check("t1_sel_we", {o_s_sel, o_s_we}, 5'b1111_1);
        check("t1_noack",  o_m_ack, 3'b000);
        next_cycle();
        s_ack = 1'b1; s_dat = 32'h1234_5678;
        settle();
        check("t1_ack",     o_m_ack, 3'b010);
        check("t1_rdat",    o_m_dat[63:32], 32'h1234_5678);
        check("t1_rdat_m0", o_m_dat[31:0], 32'h0);
        next_cycle();
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_ack = 1'b0;
        settle();
        check("t1_release", o_s_cyc, 1'b0);

        // Round-robin: all masters busy, each drops cyc for one cycle after its ack
        do_reset();
        for (int k = 0; k < 3; k++) drive(k, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(k), 32'h0, 4'hF);
        drop = '0;
        cyc_cnt = 0;
        while (order.size() < 6 && cyc_cnt < 60) begin
            next_cycle();
            cyc_cnt++;
            for (int k = 0; k < 3; k++) begin
                m_cyc[k] = ~drop[k];
                m_stb[k] = ~drop[k];
            end
            drop = '0;
            s_ack = 1'b0;
            #1;
            s_ack = o_s_stb;
            #1;
            if (o_m_ack != 3'b000) begin
                check("t2_onehot", 64'($countones(o_m_ack)), 64'd1);
                for (int k = 0; k < 3; k++) begin
                    if (o_m_ack[k]) begin
                        order.push_back(k);
                        ack_cyc.push_back(cyc_cnt);
                        drop[k] = 1'b1;
                    end
                end
            end
        end
        s_ack = 1'b0;
        m_cyc = '0; m_stb = '0;
        exp_order = '{0, 1, 2, 0, 1, 2};
        check("t2_count", 64'(order.size()), 64'd6);
        for (int i = 0; i < order.size() && i < 6; i++) begin
            check($sformatf("t2_order%0d", i), 64'(order[i]), 64'(exp_order[i]));
        end
        for (int i = 3; i < ack_cyc.size(); i++) begin
            check($sformatf("t2_gap%0d", i), 64'(ack_cyc[i] - ack_cyc[i-3] <= 9), 64'd1);
        end
        next_cycle();
        next_cycle();

        // Lock: m2 read-modify-write while m0 waits
        do_reset();
        drive(2, 1'b1, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0, 4'hF);
        next_cycle();
        drive(0, 1'b1, 1'b1, 1'b0, 32'hBBBB_0000, 32'h0, 4'hF);
        s_ack = 1'b1; s_dat = 32'hCAFE_F00D;
        settle();
        check("t3_rd_ack",  o_m_ack, 3'b100);
        check("t3_rd_dat",  o_m_dat[95:64], 32'hCAFE_F00D);
        next_cycle();
        s_ack = 1'b0;
        m_stb[2] = 1'b0;
        settle();
        check("t3_gap", {o_s_cyc, o_s_stb}, 2'b10);
        next_cycle();
        drive(2, 1'b1, 1'b1, 1'b1, 32'hAAAA_0000, 32'h5555_AAAA, 4'h3);
        s_ack = 1'b1;
        settle();
        check("t3_wr_we",  {o_s_we, o_s_sel}, 5'b1_0011);
        check("t3_wr_adr", o_s_adr, 32'hAAAA_0000);
        check("t3_wr_ack", o_m_ack, 3'b100);
        next_cycle();
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check("t3_drop_ack", o_m_ack, 3'b000);
        check("t3_drop_cyc", o_s_cyc, 1'b0);
        next_cycle(); settle();
        check("t3_idle_ack", o_m_ack, 3'b000);
        check("t3_idle_cyc", o_s_cyc, 1'b0);
        next_cycle();
        s_ack = 1'b0;
        settle();
        check("t3_m0_cyc", o_s_cyc, 1'b1);
        check("t3_m0_adr", o_s_adr, 32'hBBBB_0000);
        m_cyc = '0; m_stb = '0;
        next_cycle();
        next_cycle();

        // Reset mid-op: m1 owns with rr pointer at 2, reset must return pointer to 0
        do_reset();
        drive(1, 1'b1, 1'b1, 1'b0, 32'h1111_0000, 32'h0, 4'hF);
        next_cycle();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        next_cycle();
        drive(1, 1'b1, 1'b1, 1'b1, 32'h1111_0004, 32'h7777_8888, 4'h3);
        next_cycle(); settle();
        check("t4_owned_stb", o_s_stb, 1'b1);
        #1;
        i_reset = 1'b1;
        s_ack = 1'b1;
        #1;
        check("t4_rst_ctrl", {o_s_cyc, o_s_stb, o_s_we}, 3'b000);
        check("t4_rst_adr",  o_s_adr, 32'h0);
        check("t4_rst_dsel", {o_s_dat, o_s_sel}, 36'h0);
        check("t4_rst_mack", {o_m_ack, o_m_err}, 6'b0);
        check("t4_rst_mdat", 64'(|o_m_dat), 64'd0);
        next_cycle();
        i_reset = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0A00, 32'h0, 4'hF);
        drive(2, 1'b1, 1'b1, 1'b0, 32'h0000_0C00, 32'h0, 4'hF);
        settle();
        check("t4_late_ack", o_m_ack, 3'b000);
        next_cycle(); settle();
        check("t4_regrant_adr", o_s_adr, 32'h0000_0A00);
        check("t4_regrant_ack", o_m_ack, 3'b001);
        s_ack = 1'b0;
        m_cyc = '0; m_stb = '0;
        next_cycle();
        next_cycle();

        // Stalled slave on an m0 read
        do_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0E00, 32'h0, 4'hF);
        next_cycle();
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 0; k < 13; k++) begin
            settle();
            check($sformatf("t5_err%0d", k), o_m_err, (k == 8) ? 3'b001 : 3'b000);
            check($sformatf("t5_stb%0d", k), o_s_stb, (k == 8) ? 1'b0 : 1'b1);
            next_cycle();
        end
`else
        err_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            settle();
            if (o_m_err != 3'b000) err_cnt++;
            next_cycle();
        end
        check("t5_no_err", 64'(err_cnt), 64'd0);
`endif
        settle();
        check("t5_grant_stb", o_s_stb, 1'b1);
        check("t5_grant_adr", o_s_adr, 32'h0000_0E00);
        m_cyc = '0; m_stb = '0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
Round-robin Wishbone B4 classic arbiter that lets NUM_MASTERS requesters share one RAM slave port (a wb_openram_wrapper or wb_ram instance).
- Default master map: 0 = cpu0 ibus, 1 = cpu0 dbus, 2 = management (mprj) port.
- Sits between the interconnect outputs and the RAM wrapper.
- Grant is locked for the full CYC assertion, so multi-beat and read-modify-write cycles are atomic.

Parameters:
- NUM_MASTERS, 3, number of requesters (2..4).
- TIMEOUT, 255, stalled-cycle limit before an error is returned (used only with the optional feature).

Ports:
- i_clk  in  1  Wishbone clock
- i_reset  in  1  asynchronous, active-high reset
- i_m_adr  in  32*NUM_MASTERS  master addresses, master k at bits [32k+31:32k]
- i_m_dat  in  32*NUM_MASTERS  master write data
- i_m_sel  in  4*NUM_MASTERS  byte selects
- i_m_we  in  NUM_MASTERS  write enables
- i_m_cyc  in  NUM_MASTERS  cycle requests
- i_m_stb  in  NUM_MASTERS  strobes
- o_m_dat  out  32*NUM_MASTERS  read data returned to each master
- o_m_ack  out  NUM_MASTERS  acknowledges
- o_m_err  out  NUM_MASTERS  bus errors
- o_s_adr  out  32  slave address
- o_s_dat  out  32  slave write data
- o_s_sel  out  4  slave byte selects
- o_s_we  out  1  slave write enable
- o_s_cyc  out  1  slave cycle
- o_s_stb  out  1  slave strobe
- i_s_dat  in  32  slave read data
- i_s_ack  in  1  slave acknowledge

Behaviour:
- Reset (async, any time including mid-transfer):
  - state = IDLE, grant = none, rr pointer = 0.
  - All o_m_*, o_s_cyc, o_s_stb, o_s_we = 0; o_s_adr/dat/sel = 0.
  - Timeout counter = 0.
  - An interrupted slave cycle is abandoned; any later i_s_ack is ignored until the next grant.
- FSM has two states: IDLE and OWNED.
- IDLE:
  - If any i_m_cyc is set, select the first requester searching upward cyclically from the rr pointer.
  - The grant is registered; go to OWNED on the next edge.
  - No slave signals are driven in IDLE. Arbitration latency is 1 cycle.
- OWNED:
  - o_s_adr/dat/sel/we are a combinational mux of the owner's inputs.
  - o_s_cyc = owner cyc; o_s_stb = owner cyc & stb.
  - Owner receives o_m_dat = i_s_dat and o_m_ack = i_s_ack & owner cyc, combinationally (zero added latency).
  - Non-owners: dat = 0, ack = 0, err = 0, regardless of their cyc/stb.
- Release:
  - When the owner's i_m_cyc is 0 at an edge, return to IDLE and set rr pointer = owner+1 (mod NUM_MASTERS).
  - Minimum 1 idle cycle between grants, so the same master re-requesting immediately competes fairly.
- Simultaneous events:
  - All masters request in IDLE: the rr pointer decides.
  - A request arriving in the same cycle the owner releases is seen in the following IDLE cycle.
- Owner drops cyc with stb still high: treated as a release. A late i_s_ack is not forwarded.
- i_s_ack while no grant or owner cyc low: ignored.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Enabled:
  - A counter, width ceil(log2(TIMEOUT+1)), increments each OWNED cycle with owner stb = 1 and i_s_ack = 0.
  - It clears on ack, on release, or when it reaches TIMEOUT.
  - In the cycle the count equals TIMEOUT: o_m_err[owner] = 1 for exactly one cycle, o_s_cyc/o_s_stb are forced 0 for that cycle, and o_m_ack[owner] is forced 0.
  - Grant is retained until the owner drops cyc.
- Disabled:
  - o_m_err is tied to 0 and no counter exists.
  - A stalled slave holds the grant indefinitely.

Test Plan:
- Single master:
  - m1 write adr 0x3000_1004, dat 0xDEADBEEF, sel 0xF; slave acks 1 cycle after stb.
  - Expect o_s_stb high from the cycle after cyc rises, o_m_ack[1] in the same cycle as i_s_ack, and m0/m2 ack = 0.
- Round-robin fairness:
  - All three masters hold cyc continuously, each doing 1-beat transfers and dropping cyc for 1 cycle after ack.
  - Expected grant order after reset: 0,1,2,0,1,2.
  - Each master gets an ack within 3 × (transfer + 2) cycles.
- Lock:
  - m2 holds cyc across a read then a write (RMW) while m0 requests.
  - m0 sees no ack until m2 drops cyc; m0 is granted one idle cycle later.
- Reset mid-op:
  - Assert i_reset while m1 owns the bus with stb high; deassert; then assert i_s_ack.
  - All outputs are 0 immediately on reset; no ack is forwarded; the next grant goes to the lowest requesting index from pointer 0.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT=8):
  - m0 read, slave never acks.
  - o_m_err[0] pulses exactly once, at 8 cycles after stb first seen in OWNED.
  - o_s_stb is low that cycle and high again the next cycle while m0 keeps stb.
- Timeout disabled:
  - Same stimulus as the previous scenario.
  - o_m_err stays 0 for 1000 cycles; grant remains with m0.
